// File: rtl/bp_fe_icache_fill_engine_if.sv
// rtl/bp_fe_icache_fill_engine_if.sv - I-cache service bus between the FE, memory port and cache memory packets
interface bp_fe_icache_fill_engine_if #(
    parameter int paddr_width_p        = 40,
    parameter int ptag_width_p         = 28,
    parameter int icache_sets_p        = 64,
    parameter int icache_assoc_p       = 8,
    parameter int icache_block_width_p = 512
);
    localparam int index_width_lp = $clog2(icache_sets_p);
    localparam int way_width_lp   = $clog2(icache_assoc_p);

    logic [paddr_width_p+1:0]                                   cache_req_i;
    logic                                                       cache_req_v_i;
    logic                                                       cache_req_ready_o;
    logic [way_width_lp-1:0]                                    cache_req_metadata_i;
    logic                                                       cache_req_metadata_v_i;
    logic                                                       cache_req_complete_o;

    logic [paddr_width_p-1:0]                                   mem_cmd_addr_o;
    logic                                                       mem_cmd_v_o;
    logic                                                       mem_cmd_ready_i;
    logic [icache_block_width_p-1:0]                            mem_resp_data_i;
    logic                                                       mem_resp_v_i;
    logic                                                       mem_resp_yumi_o;

    logic [1+index_width_lp+way_width_lp+icache_block_width_p-1:0] data_mem_pkt_o;
    logic                                                       data_mem_pkt_v_o;
    logic                                                       data_mem_pkt_ready_i;
    logic [index_width_lp+way_width_lp+ptag_width_p-1:0]        tag_mem_pkt_o;
    logic                                                       tag_mem_pkt_v_o;
    logic                                                       tag_mem_pkt_ready_i;
    logic [index_width_lp+way_width_lp-1:0]                     stat_mem_pkt_o;
    logic                                                       stat_mem_pkt_v_o;
    logic                                                       stat_mem_pkt_ready_i;

    // master: the FE / memory / cache-array environment; slave: the fill engine
    modport master (
        output cache_req_i, cache_req_v_i, cache_req_metadata_i, cache_req_metadata_v_i,
        output mem_cmd_ready_i, mem_resp_data_i, mem_resp_v_i,
        output data_mem_pkt_ready_i, tag_mem_pkt_ready_i, stat_mem_pkt_ready_i,
        input  cache_req_ready_o, cache_req_complete_o,
        input  mem_cmd_addr_o, mem_cmd_v_o, mem_resp_yumi_o,
        input  data_mem_pkt_o, data_mem_pkt_v_o, tag_mem_pkt_o, tag_mem_pkt_v_o,
        input  stat_mem_pkt_o, stat_mem_pkt_v_o
    );

    modport slave (
        input  cache_req_i, cache_req_v_i, cache_req_metadata_i, cache_req_metadata_v_i,
        input  mem_cmd_ready_i, mem_resp_data_i, mem_resp_v_i,
        input  data_mem_pkt_ready_i, tag_mem_pkt_ready_i, stat_mem_pkt_ready_i,
        output cache_req_ready_o, cache_req_complete_o,
        output mem_cmd_addr_o, mem_cmd_v_o, mem_resp_yumi_o,
        output data_mem_pkt_o, data_mem_pkt_v_o, tag_mem_pkt_o, tag_mem_pkt_v_o,
        output stat_mem_pkt_o, stat_mem_pkt_v_o
    );
endinterface

// File: rtl/bp_fe_icache_fill_engine.sv
// rtl/bp_fe_icache_fill_engine.sv - single-outstanding I-cache miss/uncached fill engine
module bp_fe_icache_fill_engine #(
    parameter int paddr_width_p        = 40,
    parameter int ptag_width_p         = 28,
    parameter int icache_sets_p        = 64,
    parameter int icache_assoc_p       = 8,
    parameter int icache_block_width_p = 512
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    bp_fe_icache_fill_engine_if.slave   io
);
    localparam int index_width_lp    = $clog2(icache_sets_p);
    localparam int way_width_lp      = $clog2(icache_assoc_p);
    localparam int blk_addr_width_lp = paddr_width_p - 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_MEM_CMD,
        S_MEM_RESP,
        S_DATA,
        S_TAG,
        S_STAT,
        S_DONE
    } state_e;

    state_e                            state_r, state_n;
    logic                              ready_r;
    logic                              uncached_r;
    logic [blk_addr_width_lp-1:0]      blk_addr_r;
    logic [way_width_lp-1:0]           way_r;
    logic                              meta_v_r;
    logic [icache_block_width_p-1:0]   data_r;

    logic                              accept;
    logic                              resp_fire;
    logic                              meta_fire;
    logic [index_width_lp-1:0]         index;
    logic [ptag_width_p-1:0]           tag;
    logic [way_width_lp-1:0]           pkt_way;
    logic                              unused_addr_lsbs;

    // ready_r tracks "state is IDLE" but stays low through reset, so it never
    // advertises readiness while the engine is being cleared
    assign accept    = io.cache_req_v_i & ready_r;
    assign resp_fire = (state_r == S_MEM_RESP) & io.mem_resp_v_i;
    assign meta_fire = ((state_r == S_IDLE) | (state_r == S_REQ)) & io.cache_req_metadata_v_i;

    assign index            = blk_addr_r[index_width_lp-1:0];
    assign tag              = blk_addr_r[blk_addr_width_lp-1 -: ptag_width_p];
    assign pkt_way          = uncached_r ? '0 : way_r;
    assign unused_addr_lsbs = ^io.cache_req_i[5:0];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r    <= S_IDLE;
            ready_r    <= 1'b0;
            uncached_r <= 1'b0;
            blk_addr_r <= '0;
            way_r      <= '0;
            meta_v_r   <= 1'b0;
            data_r     <= '0;
        end else begin
            state_r <= state_n;
            ready_r <= (state_n == S_IDLE);
            if (accept) begin
                uncached_r <= io.cache_req_i[paddr_width_p];
                blk_addr_r <= io.cache_req_i[paddr_width_p-1:6];
            end
            if (meta_fire) begin
                way_r    <= io.cache_req_metadata_i;
                meta_v_r <= 1'b1;
            end else if (state_r == S_DONE) begin
                meta_v_r <= 1'b0;
            end
            if (resp_fire) begin
                data_r <= io.mem_resp_data_i;
            end
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE: begin
                // type[1] set means an illegal request: complete with no traffic
                if (accept) begin
                    state_n = io.cache_req_i[paddr_width_p+1] ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (uncached_r | meta_v_r | io.cache_req_metadata_v_i) begin
                    state_n = S_MEM_CMD;
                end
            end
            S_MEM_CMD: begin
                if (io.mem_cmd_ready_i) begin
                    state_n = S_MEM_RESP;
                end
            end
            S_MEM_RESP: begin
                if (io.mem_resp_v_i) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (io.data_mem_pkt_ready_i) begin
                    state_n = uncached_r ? S_DONE : S_TAG;
                end
            end
            S_TAG: begin
                if (io.tag_mem_pkt_ready_i) begin
                    state_n = S_STAT;
                end
            end
            S_STAT: begin
                if (io.stat_mem_pkt_ready_i) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign io.cache_req_ready_o    = ready_r;
    assign io.cache_req_complete_o = (state_r == S_DONE);

    assign io.mem_cmd_addr_o  = {blk_addr_r, 6'b0};
    assign io.mem_cmd_v_o     = (state_r == S_MEM_CMD);
    assign io.mem_resp_yumi_o = resp_fire;

    assign io.data_mem_pkt_o   = {uncached_r, index, pkt_way, data_r};
    assign io.data_mem_pkt_v_o = (state_r == S_DATA);
    assign io.tag_mem_pkt_o    = {index, way_r, tag};
    assign io.tag_mem_pkt_v_o  = (state_r == S_TAG);
    assign io.stat_mem_pkt_o   = {index, way_r};
    assign io.stat_mem_pkt_v_o = (state_r == S_STAT);
endmodule

// File: tb/tb_bp_fe_icache_fill_engine.sv
// tb/tb_bp_fe_icache_fill_engine.sv - scoreboard bench for the I-cache fill engine
module tb_bp_fe_icache_fill_engine;
    localparam int PW = 40;
    localparam int BW = 512;
    localparam int VW = 1 + 6 + 3 + BW;

    localparam int K_CMD  = 0;
    localparam int K_DATA = 1;
    localparam int K_TAG  = 2;
    localparam int K_STAT = 3;
    localparam int K_DONE = 4;

    typedef struct {
        int            kind;
        logic [VW-1:0] val;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    bit            mem_auto = 1'b1;
    logic          auto_resp_v = 1'b0;
    logic          manual_resp_v = 1'b0;
    logic [BW-1:0] mem_data = '0;
    bit            bp_en = 1'b0;
    int            data_wait = 0;
    int            tag_wait = 0;
    int            stat_wait = 0;

    bp_fe_icache_fill_engine_if bus ();

    bp_fe_icache_fill_engine dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .io        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_resp_v_i    = auto_resp_v | manual_resp_v;
    assign bus.mem_resp_data_i = mem_data;

    always @(posedge clk) begin
        data_wait <= bus.data_mem_pkt_v_o ? data_wait + 1 : 0;
        tag_wait  <= bus.tag_mem_pkt_v_o  ? tag_wait + 1  : 0;
        stat_wait <= bus.stat_mem_pkt_v_o ? stat_wait + 1 : 0;
    end
    assign bus.data_mem_pkt_ready_i = !bp_en || (data_wait >= 4);
    assign bus.tag_mem_pkt_ready_i  = !bp_en || (tag_wait >= 4);
    assign bus.stat_mem_pkt_ready_i = !bp_en || (stat_wait >= 4);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic observe(input int kind, input logic [VW-1:0] val, input bit fire);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output kind=%0d cyc=%0d got=%h", kind, cyc, val);
            return;
        end
        e = exp_q[0];
        if (e.kind != kind || e.val !== val || (fire && e.cyc != cyc)) begin
            errors++;
            $display("FAIL scoreboard kind=%0d/%0d cyc=%0d/%0d got=%h exp=%h",
                     kind, e.kind, cyc, e.cyc, val, e.val);
        end
        if (fire) void'(exp_q.pop_front());
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.mem_cmd_v_o)
                observe(K_CMD, VW'(bus.mem_cmd_addr_o), bus.mem_cmd_ready_i);
            if (bus.data_mem_pkt_v_o)
                observe(K_DATA, bus.data_mem_pkt_o, bus.data_mem_pkt_ready_i);
            if (bus.tag_mem_pkt_v_o)
                observe(K_TAG, VW'(bus.tag_mem_pkt_o), bus.tag_mem_pkt_ready_i);
            if (bus.stat_mem_pkt_v_o)
                observe(K_STAT, VW'(bus.stat_mem_pkt_o), bus.stat_mem_pkt_ready_i);
            if (bus.cache_req_complete_o)
                observe(K_DONE, '0, 1'b1);
        end
    end

    // memory model: respond in the first MEM_RESP cycle after the command
    initial begin
        int n;
        forever begin
            @(negedge clk);
            if (mem_auto && reset_n && bus.mem_cmd_v_o && bus.mem_cmd_ready_i) begin
                @(posedge clk);
                #1 auto_resp_v = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.mem_resp_yumi_o && n < 50);
                if (!bus.mem_resp_yumi_o) begin
                    errors++;
                    $display("FAIL mem_resp_timeout: yumi got 0 expected 1");
                end
                @(posedge clk);
                #1 auto_resp_v = 1'b0;
            end
        end
    end

    task automatic push(input int kind, input logic [VW-1:0] val, input int c);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic push_miss(input int t0, input int off, input int s, input logic [39:0] maddr,
                             input logic [5:0] idx, input logic [2:0] way,
                             input logic [27:0] tag, input logic [BW-1:0] d);
        push(K_CMD,  VW'(maddr), t0 + off);
        push(K_DATA, {1'b0, idx, way, d}, t0 + off + 2 + s);
        push(K_TAG,  VW'({idx, way, tag}), t0 + off + 3 + 2 * s);
        push(K_STAT, VW'({idx, way}), t0 + off + 4 + 3 * s);
        push(K_DONE, '0, t0 + off + 5 + 3 * s);
    endtask

    task automatic send_req(input logic [1:0] t, input logic [39:0] a, input bit mv,
                            input logic [2:0] w, output int t0);
        int n = 0;
        @(negedge clk);
        while (!bus.cache_req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 64'(bus.cache_req_ready_o), 64'd1);
        bus.cache_req_i            = {t, a};
        bus.cache_req_v_i          = 1'b1;
        bus.cache_req_metadata_i   = w;
        bus.cache_req_metadata_v_i = mv;
        t0 = cyc;
        @(posedge clk);
        #1;
        bus.cache_req_v_i          = 1'b0;
        bus.cache_req_metadata_v_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        bus.cache_req_i            = '0;
        bus.cache_req_v_i          = 1'b0;
        bus.cache_req_metadata_i   = '0;
        bus.cache_req_metadata_v_i = 1'b0;
        bus.mem_cmd_ready_i        = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.cache_req_ready_o), 64'd0);
        chk("rst_valids", 64'({bus.mem_cmd_v_o, bus.data_mem_pkt_v_o, bus.tag_mem_pkt_v_o,
                               bus.stat_mem_pkt_v_o, bus.cache_req_complete_o, bus.mem_resp_yumi_o}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 64'(bus.cache_req_ready_o), 64'd1);

        // miss, minimum latency: index 9, tag 0x8000001, way 5
        mem_data = {64{8'hA5}};
        send_req(2'd0, 40'h80_0000_1240, 1'b1, 3'd5, t0);
        push_miss(t0, 2, 0, 40'h80_0000_1240, 6'd9, 3'd5, 28'h8000001, {64{8'hA5}});
        wait_drain("miss_min");

        // metadata three cycles late: index 63, tag 0x1234567, way 2
        mem_data = {16{32'hDEADBEEF}};
        send_req(2'd0, 40'h12_3456_7FC5, 1'b0, 3'd0, t0);
        push_miss(t0, 4, 0, 40'h12_3456_7FC0, 6'd63, 3'd2, 28'h1234567, {16{32'hDEADBEEF}});
        while (cyc < t0 + 3) @(negedge clk);
        bus.cache_req_metadata_i   = 3'd2;
        bus.cache_req_metadata_v_i = 1'b1;
        @(posedge clk);
        #1 bus.cache_req_metadata_v_i = 1'b0;
        wait_drain("miss_late_meta");

        // uncached: opcode 1, index 1, way forced to 0 despite metadata way 6
        mem_data = {8{64'hFEDC_BA98_7654_3210}};
        send_req(2'd1, 40'h80_0000_0040, 1'b1, 3'd6, t0);
        push(K_CMD,  VW'(40'h80_0000_0040), t0 + 2);
        push(K_DATA, {1'b1, 6'd1, 3'd0, {8{64'hFEDC_BA98_7654_3210}}}, t0 + 4);
        push(K_DONE, '0, t0 + 5);
        wait_drain("uncached");

        // illegal types complete one cycle after accept with no traffic
        send_req(2'd3, 40'h11_2233_4455, 1'b1, 3'd4, t0);
        push(K_DONE, '0, t0 + 1);
        wait_drain("illegal_3");
        send_req(2'd2, 40'h00_0000_0000, 1'b0, 3'd0, t0);
        push(K_DONE, '0, t0 + 1);
        wait_drain("illegal_2");

        // backpressure: each packet stalls 4 cycles, completion at +19
        bp_en = 1'b1;
        mem_data = {8{64'h0123_4567_89AB_CDEF}};
        send_req(2'd0, 40'h00_0000_0FC0, 1'b1, 3'd7, t0);
        push_miss(t0, 2, 4, 40'h00_0000_0FC0, 6'd63, 3'd7, 28'h0000000, {8{64'h0123_4567_89AB_CDEF}});
        wait_drain("backpressure");
        bp_en = 1'b0;

        // reset while waiting in MEM_RESP
        mem_auto = 1'b0;
        send_req(2'd0, 40'h80_0000_1240, 1'b1, 3'd5, t0);
        push(K_CMD, VW'(40'h80_0000_1240), t0 + 2);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 exp_q.delete();
        @(negedge clk);
        chk("midrst_ready", 64'(bus.cache_req_ready_o), 64'd0);
        chk("midrst_valids", 64'({bus.mem_cmd_v_o, bus.data_mem_pkt_v_o, bus.tag_mem_pkt_v_o,
                                  bus.stat_mem_pkt_v_o, bus.cache_req_complete_o, bus.mem_resp_yumi_o}), 64'd0);
        reset_n = 1'b1;
        manual_resp_v = 1'b1;
        chk("midrst_late_resp_yumi", 64'(bus.mem_resp_yumi_o), 64'd0);
        @(negedge clk);
        chk("midrst_release_ready", 64'(bus.cache_req_ready_o), 64'd1);
        chk("midrst_no_complete", 64'({bus.cache_req_complete_o, bus.mem_resp_yumi_o}), 64'd0);
        @(posedge clk);
        #1 manual_resp_v = 1'b0;
        mem_auto = 1'b1;

        // a fresh miss after the abandoned one: index 0, tag 0x7FFFFFF, way 0
        mem_data = {64{8'h3C}};
        send_req(2'd0, 40'h7F_FFFF_F000, 1'b1, 3'd0, t0);
        push_miss(t0, 2, 0, 40'h7F_FFFF_F000, 6'd0, 3'd0, 28'h7FFFFFF, {64{8'h3C}});
        wait_drain("post_reset_miss");

        chk("final_ready", 64'(bus.cache_req_ready_o), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
